spi_ram_bridge: RTL and testbench
=================================

// Module: spi_ram_bridge
// PURPOSE
//   Parametrised command-decoding RAM behind the SPI slave. Consumes 2-bit-opcode command words from the
//   SPI receive path, keeps separate write/read address pointers, returns read data with a valid/ready handshake.
//   Adds backpressure (rx_ready), registered RAM output stage, and overrun reporting.
// PARAMETERS
//   DATA_W  8            data word width (din payload and dout)
//   ADDR_W  8            address width; must satisfy ADDR_W <= DATA_W (address carried in payload)
//   DEPTH   1<<ADDR_W    memory depth in words; pointers wrap at DEPTH-1 -> 0
// PORTS
//   clk       in   1         single clock, all logic on posedge
//   rst       in   1         reset, synchronous, active-high
//   din       in   DATA_W+2  command word: din[DATA_W+1:DATA_W]=opcode, din[DATA_W-1:0]=payload
//   rx_valid  in   1         din valid; word accepted on edge where rx_valid && rx_ready
//   rx_ready  out  1         high only in IDLE
//   dout      out  DATA_W    read data, stable while tx_valid high
//   tx_valid  out  1         dout valid; held until accepted
//   tx_ready  in   1         downstream accept; transfer on edge where tx_valid && tx_ready
//   overrun   out  1         one-cycle pulse: rx_valid seen while rx_ready low (word dropped)
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, addr_wr=0, addr_rd=0, dout=0, tx_valid=0, overrun=0, rx_ready=1
//     next cycle. Memory contents NOT cleared. Reset wins over any in-flight read (RD or TX abandoned).
//   Opcodes on accepted word (IDLE only):
//     2'b00 WR_ADDR: addr_wr <= payload[ADDR_W-1:0]; stay IDLE
//     2'b01 WR_DATA: mem[addr_wr] <= payload; stay IDLE
//     2'b10 RD_ADDR: addr_rd <= payload[ADDR_W-1:0]; stay IDLE
//     2'b11 RD_DATA: payload ignored; rd_q <= mem[addr_rd]; -> RD
//   Payload bits above ADDR_W-1 ignored for address opcodes. Address >= DEPTH (non-power-of-2) wraps mod DEPTH.
//   FSM: IDLE -(RD_DATA accepted)-> RD -(always)-> TX -(tx_ready)-> IDLE.
//     RD: dout <= rd_q, tx_valid <= 1. TX: tx_valid=1, dout held; on tx_valid&&tx_ready, tx_valid <= 0.
//   Latency: RD_DATA accepted at edge N -> tx_valid high from edge N+2. tx_ready high on first TX cycle
//     -> single-cycle tx_valid, rx_ready high from edge N+3.
//   rx_ready = (state==IDLE), combinational from state. Words offered in RD/TX are dropped, overrun pulses
//     the following cycle; no state/pointer change.
//   Single-port: write and read never share a cycle (reads only via RD_DATA in IDLE).
//   Write-then-read of same address returns the newly written value (write completes before RD_DATA decode).
// CONFIGURATION
//   SPI_RAM_AUTOINC_EN defined: after WR_DATA addr_wr <= addr_wr+1; after RD_DATA acceptance
//     addr_rd <= addr_rd+1; both wrap DEPTH-1 -> 0. Enables burst access without re-sending address.
//   Not defined: pointers change only on WR_ADDR/RD_ADDR (legacy behaviour).
// STRUCTURE
//   Package spi_ram_pkg: opcode localparams OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10,
//     OP_RD_DATA=2'b11; state encoding ST_IDLE/ST_RD/ST_TX (2 bits).
//   Sub-module spi_ram_mem: single-port synchronous RAM (DATA_W x DEPTH, we, addr, wdata, registered rdata);
//     top holds FSM, pointers, handshakes, overrun.
// TESTING
//   Reset, then WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA, tx_ready=1 -> dout=0xA5, tx_valid 1 cycle, 2 cycles after RD_DATA.
//   RD_DATA with tx_ready=0 for 5 cycles -> tx_valid/dout held, rx_ready=0; extra word offered -> overrun pulse, memory unchanged.
//   AUTOINC_EN: WR_ADDR 0xFF, WR_DATA 0x11, 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22; reads from 0xFF return 0x11 then 0x22.
//   No AUTOINC_EN: two RD_DATA from addr 0x05 (mem=0x3C) -> both return 0x3C; addr_rd stays 0x05.
//   rst asserted during TX -> next cycle tx_valid=0, dout=0, rx_ready=1; prior writes still readable.
//   Random command stream vs. reference model with random tx_ready stalls -> every tx transfer matches model.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared opcode and FSM state encodings for the SPI command RAM bridge.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_TX   = 2'd2
  } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM, DATA_W x DEPTH, one-cycle registered read; contents have no reset.
// Write and read share one address port, so the caller never asserts we and re together.
module spi_ram_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_bridge.sv
// Command-decoding RAM behind an SPI slave: RD_DATA accepted at edge N gives tx_valid after edge N+1.
// rx_ready is high only in IDLE; offered words elsewhere are dropped and pulse overrun. SPI_RAM_AUTOINC_EN adds pointer post-increment.
module spi_ram_bridge #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              overrun
);
  import spi_ram_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
  logic [ADDR_W-1:0] addr_rd_q, addr_rd_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic              overrun_q, overrun_d;

  logic [1:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] payload_addr;
  logic              accept;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign opcode       = din[DATA_W+1:DATA_W];
  assign payload      = din[DATA_W-1:0];
  // Out-of-range addresses fold back into the array when DEPTH is not a power of two.
  assign payload_addr = ADDR_W'(32'(payload[ADDR_W-1:0]) % DEPTH);
  assign accept       = rx_valid && (state_q == ST_IDLE) && !rst;

`ifdef SPI_RAM_AUTOINC_EN
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    addr_wr_d  = addr_wr_q;
    addr_rd_d  = addr_rd_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    overrun_d  = rx_valid && (state_q != ST_IDLE);
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = addr_wr_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (opcode)
            OP_WR_ADDR: addr_wr_d = payload_addr;
            OP_WR_DATA: begin
              mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
              addr_wr_d = ptr_inc(addr_wr_q);
`endif
            end
            OP_RD_ADDR: addr_rd_d = payload_addr;
            default: begin
              mem_re   = 1'b1;
              mem_addr = addr_rd_q;
              state_d  = ST_RD;
`ifdef SPI_RAM_AUTOINC_EN
              addr_rd_d = ptr_inc(addr_rd_q);
`endif
            end
          endcase
        end
      end
      ST_RD: begin
        dout_d     = mem_rdata;
        tx_valid_d = 1'b1;
        state_d    = ST_TX;
      end
      ST_TX: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset abandons any read in RD or TX; RAM contents survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_wr_q  <= '0;
      addr_rd_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_wr_q  <= addr_wr_d;
      addr_rd_q  <= addr_rd_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  spi_ram_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(payload),
    .rdata(mem_rdata)
  );

  assign rx_ready = (state_q == ST_IDLE);
  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Directed and random-stream bench for spi_ram_bridge (8-bit data, 8-bit address, 256 words).
module tb_spi_ram_bridge;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] dout;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       overrun;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] model [256];

  spi_ram_bridge #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .dout(dout), .tx_valid(tx_valid), .tx_ready(tx_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] pl);
    din = {op, pl};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Issues RD_DATA, waits (bounded) for tx_valid, holds for 'stall' cycles, then accepts.
  task automatic rd_data(input int stall, output logic [7:0] d, output bit ok);
    tx_ready = 1'b0;
    send(RD_DATA, 8'h00);
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      tick();
      ok = (tx_valid === 1'b1);
    end
    repeat (stall) tick();
    d = dout;
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_basic();
    send(WR_ADDR, 8'h10);
    send(WR_DATA, 8'hA5);
    send(RD_ADDR, 8'h10);
    tx_ready = 1'b1;
    send(RD_DATA, 8'h00);
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_txv_n: got %b want 0", tx_valid); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_rxr_n: got %b want 0", rx_ready); end
    tick();
    n_cmp++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_txv_n1: got %b want 1", tx_valid); end
    n_cmp++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL basic_dout: got %h want a5", dout); end
    tick();
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_txv_n2: got %b want 0", tx_valid); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL basic_rxr_n2: got %b want 1", rx_ready); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b want 0", overrun); end
    tx_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0] d;
    bit ok;
    send(WR_ADDR, 8'h20);
    send(WR_DATA, 8'h5A);
    send(WR_ADDR, 8'h20);
    send(RD_ADDR, 8'h20);
    tx_ready = 1'b0;
    send(RD_DATA, 8'h00);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL stall_txv[%0d]: got %b want 1", i, tx_valid); end
      n_cmp++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL stall_dout[%0d]: got %h want 5a", i, dout); end
      n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL stall_rxr[%0d]: got %b want 0", i, rx_ready); end
      if (i == 1) begin
        din = {WR_DATA, 8'hFF};
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      if (i == 1) begin
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL stall_overrun_pulse: got %b want 1", overrun); end
      end
      if (i == 2) begin
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL stall_overrun_end: got %b want 0", overrun); end
      end
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", tx_valid); end
    send(RD_ADDR, 8'h20);
    rd_data(0, d, ok);
    n_cmp++; if (!ok || d !== 8'h5A) begin n_fail++; $display("FAIL stall_mem_kept: got %h (valid seen %0d) want 5a", d, ok); end
  endtask

`ifdef SPI_RAM_AUTOINC_EN
  task automatic test_autoinc();
    logic [7:0] d;
    bit ok;
    send(WR_ADDR, 8'hFF);
    send(WR_DATA, 8'h11);
    send(WR_DATA, 8'h22);
    send(RD_ADDR, 8'hFF);
    rd_data(0, d, ok);
    n_cmp++; if (!ok || d !== 8'h11) begin n_fail++; $display("FAIL autoinc_rd0: got %h want 11", d); end
    rd_data(1, d, ok);
    n_cmp++; if (!ok || d !== 8'h22) begin n_fail++; $display("FAIL autoinc_rd1_wrap: got %h want 22", d); end
  endtask
`else
  task automatic test_no_autoinc();
    logic [7:0] d;
    bit ok;
    send(WR_ADDR, 8'h06);
    send(WR_DATA, 8'h77);
    send(WR_ADDR, 8'h05);
    send(WR_DATA, 8'hC3);
    send(WR_DATA, 8'h3C);
    send(RD_ADDR, 8'h05);
    rd_data(0, d, ok);
    n_cmp++; if (!ok || d !== 8'h3C) begin n_fail++; $display("FAIL legacy_rd0: got %h want 3c", d); end
    rd_data(2, d, ok);
    n_cmp++; if (!ok || d !== 8'h3C) begin n_fail++; $display("FAIL legacy_rd1: got %h want 3c", d); end
    send(RD_ADDR, 8'h06);
    rd_data(0, d, ok);
    n_cmp++; if (!ok || d !== 8'h77) begin n_fail++; $display("FAIL legacy_wr_ptr_held: got %h want 77", d); end
  endtask
`endif

  task automatic test_reset_in_tx();
    logic [7:0] d;
    bit ok;
    send(WR_ADDR, 8'h00);
    send(WR_DATA, 8'h42);
    send(WR_ADDR, 8'h30);
    send(WR_DATA, 8'h99);
    send(RD_ADDR, 8'h30);
    tx_ready = 1'b0;
    send(RD_DATA, 8'h00);
    tick();
    n_cmp++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL rsttx_pre_txv: got %b want 1", tx_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rsttx_txv: got %b want 0", tx_valid); end
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rsttx_dout: got %h want 00", dout); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rsttx_rxr: got %b want 1", rx_ready); end
    rd_data(0, d, ok);
    n_cmp++; if (!ok || d !== 8'h42) begin n_fail++; $display("FAIL rsttx_rd_ptr_zero: got %h want 42", d); end
    send(WR_DATA, 8'h55);
    send(RD_ADDR, 8'h00);
    rd_data(0, d, ok);
    n_cmp++; if (!ok || d !== 8'h55) begin n_fail++; $display("FAIL rsttx_wr_ptr_zero: got %h want 55", d); end
    send(RD_ADDR, 8'h30);
    rd_data(0, d, ok);
    n_cmp++; if (!ok || d !== 8'h99) begin n_fail++; $display("FAIL rsttx_mem_kept: got %h want 99", d); end
  endtask

  task automatic test_random();
    logic [7:0] mwr, mrd, d, pl;
    logic [1:0] op;
    bit ok;
    for (int a = 0; a < 256; a++) begin
      model[a] = 8'(a) ^ 8'h5A;
      send(WR_ADDR, 8'(a));
      send(WR_DATA, model[a]);
    end
`ifdef SPI_RAM_AUTOINC_EN
    mwr = 8'h00;
`else
    mwr = 8'hFF;
`endif
    send(RD_ADDR, 8'h00);
    mrd = 8'h00;
    for (int n = 0; n < 300; n++) begin
      op = 2'($urandom_range(0, 3));
      pl = 8'($urandom_range(0, 255));
      case (op)
        WR_ADDR: begin send(op, pl); mwr = pl; end
        WR_DATA: begin
          send(op, pl);
          model[mwr] = pl;
`ifdef SPI_RAM_AUTOINC_EN
          mwr = mwr + 8'd1;
`endif
        end
        RD_ADDR: begin send(op, pl); mrd = pl; end
        default: begin
          rd_data(int'($urandom_range(0, 3)), d, ok);
          n_cmp++;
          if (!ok || d !== model[mrd]) begin
            n_fail++;
            $display("FAIL random_rd[%0d] addr %h: got %h (valid seen %0d) want %h", n, mrd, d, ok, model[mrd]);
          end
`ifdef SPI_RAM_AUTOINC_EN
          mrd = mrd + 8'd1;
`endif
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
`ifdef SPI_RAM_AUTOINC_EN
    test_autoinc();
`else
    test_no_autoinc();
`endif
    test_reset_in_tx();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
